// File: rtl/imm_pkg.sv
// Shared definitions for the immediate decode stage: format selector encodings
// and the default datapath width.
package imm_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

endpackage

// File: rtl/imm_format_decode.sv
// Combinational immediate extraction: picks the format's bit fields out of the
// instruction word and sign-extends from instr[31] to XLEN bits.
module imm_format_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        unused_opcode;

    // The opcode field carries no immediate bits in any format.
    assign unused_opcode = ^instr[6:0];

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            default: illegal = 1'b1;
        endcase
    end

    // U-type is sign-extended too, so RV64 sees bits 63:32 copy instr[31].
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: format decode followed by a two-entry skid buffer so
// in_ready is registered and never depends combinationally on out_ready.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             in_ready_q;
    logic             push, pop;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;

    logic [XLEN-1:0]  head_imm, tail_imm;
    logic [TAG_W-1:0] head_tag, tail_tag;
    logic             head_ill, tail_ill;

    imm_format_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign push      = in_valid && in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign pop       = out_valid && out_ready;
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // NOTE: both entries are reset because the head drives the outputs, which must read zero in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_imm <= '0;
            head_tag <= '0;
            head_ill <= 1'b0;
            tail_imm <= '0;
            tail_tag <= '0;
            tail_ill <= 1'b0;
        end else if (state_q == TWO) begin
            if (pop) begin
                head_imm <= tail_imm;
                head_tag <= tail_tag;
                head_ill <= tail_ill;
            end
        end else if (push) begin
            // A new entry lands in the head when the head is free or leaving this cycle.
            if (state_q == EMPTY || pop) begin
                head_imm <= dec_imm;
                head_tag <= in_tag;
                head_ill <= dec_illegal;
            end else begin
                tail_imm <= dec_imm;
                tail_tag <= in_tag;
                tail_ill <= dec_illegal;
            end
        end
    end

    assign out_imm     = head_imm;
    assign out_tag     = head_tag;
    assign out_illegal = head_ill;

endmodule
